// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, opcodes and decode-stage types shared with alu
package alu_pkg;
  localparam int CTR_W = 6;

  localparam logic [CTR_W-1:0] ALU_NOP  = 6'd0;
  localparam logic [CTR_W-1:0] ALU_ADD  = 6'd1;
  localparam logic [CTR_W-1:0] ALU_SUB  = 6'd2;
  localparam logic [CTR_W-1:0] ALU_SLL  = 6'd3;
  localparam logic [CTR_W-1:0] ALU_SRL  = 6'd4;
  localparam logic [CTR_W-1:0] ALU_SLTU = 6'd5;
  localparam logic [CTR_W-1:0] ALU_XOR  = 6'd6;
  localparam logic [CTR_W-1:0] ALU_OR   = 6'd7;
  localparam logic [CTR_W-1:0] ALU_AND  = 6'd8;
  localparam logic [CTR_W-1:0] ALU_ADDI = 6'd9;
  localparam logic [CTR_W-1:0] ALU_XORI = 6'd10;
  localparam logic [CTR_W-1:0] ALU_ORI  = 6'd11;
  localparam logic [CTR_W-1:0] ALU_ANDI = 6'd12;
  localparam logic [CTR_W-1:0] ALU_SLLI = 6'd13;
  localparam logic [CTR_W-1:0] ALU_SRLI = 6'd14;
  localparam logic [CTR_W-1:0] ALU_LW   = 6'd15;
  localparam logic [CTR_W-1:0] ALU_SW   = 6'd16;
  localparam logic [CTR_W-1:0] ALU_BEQ  = 6'd17;
  localparam logic [CTR_W-1:0] ALU_LUI  = 6'd18;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {IMM_RS2, IMM_I, IMM_SHAMT, IMM_ZERO} imm_sel_t;

  typedef struct packed {
    logic [CTR_W-1:0] alu_ctr;
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      instr;
    logic             illegal;
  } entry_t;

  // Stores keep rs2 as data2: the address immediate is rebuilt from instr by the ALU.
  function automatic imm_sel_t imm_sel_of(input logic [CTR_W-1:0] c);
    if ((c >= ALU_ADDI && c <= ALU_ANDI) || c == ALU_LW) return IMM_I;
    if (c == ALU_SLLI || c == ALU_SRLI)                   return IMM_SHAMT;
    if ((c >= ALU_ADD && c <= ALU_AND) || c == ALU_SW || c == ALU_BEQ) return IMM_RS2;
    return IMM_ZERO;
  endfunction
endpackage

// File: rtl/alu_ctr_comb.sv
// rtl/alu_ctr_comb.sv - combinational opcode/funct3/funct7 decode into ALU control code
module alu_ctr_comb
  import alu_pkg::*;
(
  input  logic [31:0]      instr,
  output logic [CTR_W-1:0] alu_ctr,
  output imm_sel_t         imm_sel,
  output logic             illegal
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    alu_ctr = ALU_NOP;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alu_ctr = ALU_ADD;
            3'b001:  alu_ctr = ALU_SLL;
            3'b101:  alu_ctr = ALU_SRL;
            3'b011:  alu_ctr = ALU_SLTU;
            3'b100:  alu_ctr = ALU_XOR;
            3'b110:  alu_ctr = ALU_OR;
            3'b111:  alu_ctr = ALU_AND;
            default: alu_ctr = ALU_NOP;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          alu_ctr = ALU_SUB;
        end
      end
      OP_I: begin
        case (funct3)
          3'b000:  alu_ctr = ALU_ADDI;
          3'b100:  alu_ctr = ALU_XORI;
          3'b110:  alu_ctr = ALU_ORI;
          3'b111:  alu_ctr = ALU_ANDI;
          3'b001:  alu_ctr = (funct7 == 7'b0) ? ALU_SLLI : ALU_NOP;
          3'b101:  alu_ctr = (funct7 == 7'b0) ? ALU_SRLI : ALU_NOP;
          default: alu_ctr = ALU_NOP;
        endcase
      end
      OP_LOAD:   if (funct3 == 3'b010) alu_ctr = ALU_LW;
      OP_STORE:  if (funct3 == 3'b010) alu_ctr = ALU_SW;
      OP_BRANCH: if (funct3 == 3'b000) alu_ctr = ALU_BEQ;
      OP_LUI:    alu_ctr = ALU_LUI;
      default:   alu_ctr = ALU_NOP;
    endcase
  end

  assign imm_sel = imm_sel_of(alu_ctr);
  assign illegal = (alu_ctr == ALU_NOP);
endmodule

// File: rtl/alu_ctr_decode.sv
// rtl/alu_ctr_decode.sv - decode/issue stage with registered output and one-entry skid buffer
module alu_ctr_decode
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs1_data,
  input  logic [31:0]      in_rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTR_W-1:0] out_alu_ctr,
  output logic [31:0]      out_data1,
  output logic [31:0]      out_data2,
  output logic [31:0]      out_instr,
  output logic             out_illegal
);
  logic [CTR_W-1:0] dec_ctr;
  imm_sel_t         dec_sel;
  logic             dec_illegal;
  entry_t           dec, out_q, skid_q;
  logic             skid_valid;
  logic             accept, fire;

  alu_ctr_comb u_comb (
    .instr   (in_instr),
    .alu_ctr (dec_ctr),
    .imm_sel (dec_sel),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec         = '0;
    dec.alu_ctr = dec_ctr;
    dec.data1   = in_rs1_data;
    dec.instr   = in_instr;
    dec.illegal = dec_illegal;
    case (dec_sel)
      IMM_I:     dec.data2 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_SHAMT: dec.data2 = {27'd0, in_instr[24:20]};
      IMM_RS2:   dec.data2 = in_rs2_data;
      default:   dec.data2 = 32'd0;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  // in_ready can only be high with the skid empty, so a skid drain never meets an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (accept && (!out_valid || fire)) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end else if (fire) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_alu_ctr = out_q.alu_ctr;
  assign out_data1   = out_q.data1;
  assign out_data2   = out_q.data2;
  assign out_instr   = out_q.instr;
  assign out_illegal = out_q.illegal;
endmodule

// File: doc/alu_ctr_decode.md
# alu_ctr_decode

Decode/issue stage that sits in front of the `alu` block and drives its `alu_ctr`, `data1`, `data2` and `instruction` inputs. It accepts one fetched instruction with its register-file operands per valid/ready handshake and decodes the opcode, funct3 and funct7 fields into the team's 6-bit ALU control code. It selects the second operand (register or immediate) and presents the result from a registered output stage backed by a one-entry skid buffer, so `in_ready` is a register output.

## Interface
- No parameters; XLEN fixed at 32, control code width fixed at 6.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous pipeline kill. Drops all held and incoming entries.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage can accept. Registered; equals `~skid_valid`.
- `in_instr` in 32: raw RV32 instruction word.
- `in_rs1_data` in 32: rs1 register value.
- `in_rs2_data` in 32: rs2 register value.
- `out_valid` out 1: decoded entry valid.
- `out_ready` in 1: ALU/EX stage consumes the entry.
- `out_alu_ctr` out 6: ALU control code (see Operation).
- `out_data1` out 32: ALU data1 (rs1).
- `out_data2` out 32: ALU data2 (selected operand).
- `out_instr` out 32: instruction word forwarded to the ALU `instruction` input.
- `out_illegal` out 1: the entry is not in the supported subset.

## Operation
- Control codes: 0 illegal/nop; 1 add; 2 sub; 3 sll; 4 srl; 5 sltu; 6 xor; 7 or; 8 and; 9 addi; 10 xori; 11 ori; 12 andi; 13 slli; 14 srli; 15 lw (address add); 16 sw (address add, immediate from instr); 17 beq (sub, zero flag); 18 lui.
- R-type, opcode 0110011:
  - funct7 0000000 with funct3 000/001/101/011/100/110/111 maps to 1/3/4/5/6/7/8.
  - funct7 0100000 with funct3 000 maps to 2.
  - Anything else is illegal.
- I-type, opcode 0010011:
  - funct3 000/100/110/111 maps to 9/10/11/12.
  - funct3 001 or 101 with instr[31:25]=0 maps to 13/14.
  - Anything else is illegal.
- Opcode 0000011 with funct3 010 maps to 15.
- Opcode 0100011 with funct3 010 maps to 16.
- Opcode 1100011 with funct3 000 maps to 17.
- Opcode 0110111 maps to 18.
- Every other instruction is illegal.
- data1 is always `in_rs1_data`.
- data2 selection:
  - Codes 9–12 and 15: sign-extended instr[31:20].
  - Codes 13–14: zero-extended instr[24:20].
  - Codes 1–8, 16, 17: `in_rs2_data`.
  - Code 18: 0.
  - Illegal: 0.
- Illegal entries still flow with `out_alu_ctr`=0 and `out_illegal`=1. They are never dropped.
- Buffering:
  - Accept condition is `in_valid & in_ready`.
  - An accepted entry goes to the output register if it is empty or firing (`out_valid & out_ready`); otherwise it goes to the skid register.
  - When the output register fires and the skid register is full, the skid entry moves to the output register and the skid register empties.
  - Ordering is strictly FIFO.

## Timing
- Latency: an instruction accepted at edge N is visible on `out_*` after edge N. Sustained throughput is 1 per cycle with `out_ready` held high.
- Reset, asynchronous: `out_valid`=0, `in_ready`=1, `out_alu_ctr`=0, `out_data1`=0, `out_data2`=0, `out_instr`=0, `out_illegal`=0, skid empty.
- Reset asserted mid-transfer discards every entry.
- Full: with both entries held, `in_ready`=0 from the next edge. `in_valid` is ignored while `in_ready`=0.
- Simultaneous out-fire and in-accept with skid empty: the new entry replaces the output. No bubble.
- Simultaneous out-fire and in-accept with skid full cannot occur, because `in_ready`=0.
- `flush` has priority over everything:
  - At the edge: `out_valid`=0, skid empty, `in_ready`=1.
  - The input presented in the flush cycle is dropped.
  - Data registers may hold stale values.
- `out_*` payload is stable while `out_valid & ~out_ready`.

## Structure
- Shared package `alu_pkg`:
  - Localparams for control codes 0–18 (`ALU_ADD`…`ALU_LUI`).
  - Opcode constants (`OP_R`, `OP_I`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_LUI`).
  - Code width 6.
  - The same package is used by `alu`.
- Sub-module `alu_ctr_comb`: purely combinational decode, `instr` in; `alu_ctr`, `imm_sel`, `illegal` out.
- The top level holds the output register, the skid register and the operand mux.

## Test plan
- R-type decode: `0x002081B3` (add x3,x1,x2), rs1=5, rs2=7 -> one cycle later `out_alu_ctr`=1, `out_data1`=5, `out_data2`=7, `out_illegal`=0. Then `0x402081B3` -> code 2.
- I-type immediate: `0xFFF00093` (addi x1,x0,-1) -> code 9, `out_data2`=`0xFFFFFFFF`. Then `0x01F09093` (slli x1,x1,31) -> code 13, `out_data2`=31.
- LUI and illegal: `0x123452B7` -> code 18, `out_data2`=0. Then `0xFFFFFFFF` -> code 0, `out_illegal`=1, `out_valid`=1.
- Backpressure: stream 3 instructions with `out_ready`=0.
  - First lands in the output register, second in the skid register.
  - `in_ready` reads 0 after the second accept; the third is held upstream.
  - Release `out_ready`: outputs appear in order 1, 2, 3, with no loss or duplication.
- Flush with both entries full: assert `flush` with `in_valid`=1 -> next cycle `out_valid`=0 and `in_ready`=1; the flush-cycle input never appears.
- Async reset: drop `rst_n` mid-stream between edges -> all outputs reach reset values immediately. After release, the first accepted entry decodes correctly.
